// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory channel with in-order read response routing; define MEM_ARB_STATS_EN for read/write counters
module mem_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 512,
  parameter int ROUTE_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_iswrite,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic                      mem_req_valid,
  output logic                      mem_req_iswrite,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [DATA_W-1:0]         mem_req_data,
  input  logic                      mem_req_grant,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W-1:0]         mem_resp_data,
  output logic                      mem_resp_grant,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  input  logic [NUM_REQ-1:0]        resp_grant,
  output logic [31:0]               stat_reads_out,
  output logic [31:0]               stat_writes_out
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(ROUTE_DEPTH);
  typedef enum logic {ARB, HOLD} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] sel_q, sel_d, rr_ptr_q, rr_ptr_d, arb_sel, sel, head;
  logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] route_q [ROUTE_DEPTH];
  logic [IW-1:0] route_d [ROUTE_DEPTH];
  logic [NUM_REQ-1:0] elig;
  logic arb_found, full, empty, accept, push, pop;
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty = wr_ptr_q == rd_ptr_q;
  assign elig  = req_valid & (req_iswrite | {NUM_REQ{~full}});
  assign head  = route_q[rd_ptr_q[PW-1:0]];
  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    logic [IW-1:0] idx;
    idx = '0;
    arb_found = 1'b0;
    arb_sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (elig[idx]) begin
        arb_found = 1'b1;
        arb_sel = idx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    route_q <= route_d;
  end
  always_comb begin
    state_d  = state_q == ARB ? ((arb_found & ~mem_req_grant) ? HOLD : ARB) : (mem_req_grant ? ARB : HOLD);
    sel_d    = state_q == ARB ? arb_sel : sel_q;
    rr_ptr_d = ~accept ? rr_ptr_q : ((sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1);
    wr_ptr_d = wr_ptr_q + (PW + 1)'(push);
    rd_ptr_d = rd_ptr_q + (PW + 1)'(pop);
    route_d  = route_q;
    if (push) route_d[wr_ptr_q[PW-1:0]] = sel;
  end
  always_comb begin
    sel             = state_q == HOLD ? sel_q : arb_sel;
    mem_req_valid   = ~rst & ((state_q == HOLD) | arb_found);
    mem_req_iswrite = req_iswrite[sel];
    mem_req_addr    = req_addr[int'(sel)*ADDR_W +: ADDR_W];
    mem_req_data    = req_data[int'(sel)*DATA_W +: DATA_W];
    accept          = mem_req_valid & mem_req_grant;
    req_grant       = accept ? NUM_REQ'(1) << sel : '0;
    push            = accept & ~mem_req_iswrite & ~full;
    resp_valid      = (empty | rst) ? '0 : {NUM_REQ{mem_resp_valid}} & (NUM_REQ'(1) << head);
    resp_data       = mem_resp_data;
    mem_resp_grant  = ~empty & ~rst & resp_grant[head];
    pop             = mem_resp_valid & mem_resp_grant;
  end
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_reads_q, stat_reads_d, stat_writes_q, stat_writes_d;
  always_comb begin
    stat_reads_d  = stat_reads_q + 32'(accept & ~mem_req_iswrite & ~&stat_reads_q);
    stat_writes_d = stat_writes_q + 32'(accept & mem_req_iswrite & ~&stat_writes_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  end
  assign stat_reads_out  = stat_reads_q;
  assign stat_writes_out = stat_writes_q;
`else
  assign stat_reads_out  = '0;
  assign stat_writes_out = '0;
`endif
  resp_needs_tag: assert property (@(posedge clk) disable iff (rst) !(mem_resp_valid && empty));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks with a read-route scoreboard for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int N = 4, AW = 64, DW = 512, D = 16;
`ifdef MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct packed {int id; logic [AW-1:0] addr;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_iswrite = '0, resp_grant = '0;
  logic [N-1:0] req_grant, resp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic mem_req_grant = 1'b0, mem_resp_valid = 1'b0;
  logic mem_req_valid, mem_req_iswrite, mem_resp_grant;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data, resp_data;
  logic [DW-1:0] mem_resp_data = '0;
  logic [31:0] stat_reads_out, stat_writes_out;
  exp_t sb[$];
  int checks = 0, errors = 0, exp_reads = 0, exp_writes = 0;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROUTE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_iswrite(req_iswrite), .req_addr(req_addr),
    .req_data(req_data), .req_grant(req_grant), .mem_req_valid(mem_req_valid),
    .mem_req_iswrite(mem_req_iswrite), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_grant(mem_req_grant), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_grant(mem_resp_grant), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_grant(resp_grant), .stat_reads_out(stat_reads_out), .stat_writes_out(stat_writes_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return {8{a ^ 64'h5A5A_0000_C3C3_0000}};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a);
    req_valid[i] = v;
    req_iswrite[i] = w;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = ~dat(a);
  endtask

  task automatic expect_rd(input int id, input logic [AW-1:0] a);
    sb.push_back('{id: id, addr: a});
    exp_reads++;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      cyc();
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_sb_empty k=%0d got no expected entry, want one", k);
        break;
      end
      e = sb.pop_front();
      resp_grant = '1;
      mem_resp_valid = 1'b1;
      mem_resp_data = dat(e.addr);
      #1;
      checks++;
      if (resp_valid !== N'(1) << e.id || resp_data !== dat(e.addr) || mem_resp_grant !== 1'b1) begin
        errors++;
        $display("FAIL drain_resp k=%0d got resp_valid=%b mem_resp_grant=%b, want resp_valid=%b mem_resp_grant=1",
                 k, resp_valid, mem_resp_grant, N'(1) << e.id);
      end
    end
    cyc();
    mem_resp_valid = 1'b0;
    resp_grant = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    sb.delete();
    exp_reads = 0;
    exp_writes = 0;
    #1;
    checks++;
    if (req_grant !== '0 || mem_req_valid !== 1'b0 || resp_valid !== '0 || mem_resp_grant !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b mem_req_valid=%b resp_valid=%b mem_resp_grant=%b, want all 0",
               req_grant, mem_req_valid, resp_valid, mem_resp_grant);
    end
    checks++;
    if (stat_reads_out !== 32'd0 || stat_writes_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d want 0/0", stat_reads_out, stat_writes_out);
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) begin
      int want;
      cyc();
      if (k == 0) begin
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 64'h1000 + 64'(i * 16));
        mem_req_grant = 1'b1;
      end
      #1;
      want = k % N;
      checks++;
      if (req_grant !== N'(1) << want || mem_req_addr !== 64'h1000 + 64'(want * 16)) begin
        errors++;
        $display("FAIL rr_grant k=%0d got grant=%b addr=%h want grant=%b", k, req_grant, mem_req_addr, N'(1) << want);
      end
      expect_rd(want, 64'h1000 + 64'(want * 16));
    end
    cyc();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0);
    drain(5);
  endtask

  task automatic test_backpressure();
    cyc();
    mem_req_grant = 1'b0;
    set_req(2, 1'b1, 1'b1, 64'h40);
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h40 || mem_req_iswrite !== 1'b1 || mem_req_data !== ~dat(64'h40) || req_grant !== '0) begin
      errors++;
      $display("FAIL bp_first got valid=%b addr=%h wr=%b grant=%b want valid=1 addr=40 wr=1 grant=0000",
               mem_req_valid, mem_req_addr, mem_req_iswrite, req_grant);
    end
    for (int k = 1; k < 5; k++) begin
      cyc();
      if (k == 1) set_req(1, 1'b1, 1'b0, 64'h80);
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h40 || req_grant !== '0) begin
        errors++;
        $display("FAIL bp_hold k=%0d got valid=%b addr=%h grant=%b want valid=1 addr=40 grant=0000",
                 k, mem_req_valid, mem_req_addr, req_grant);
      end
    end
    cyc();
    mem_req_grant = 1'b1;
    #1;
    checks++;
    if (req_grant !== 4'b0100 || mem_req_addr !== 64'h40) begin
      errors++;
      $display("FAIL bp_release got grant=%b addr=%h want grant=0100 addr=40", req_grant, mem_req_addr);
    end
    exp_writes++;
    cyc();
    set_req(2, 1'b0, 1'b0, '0);
    #1;
    checks++;
    if (req_grant !== 4'b0010 || mem_req_addr !== 64'h80 || mem_req_iswrite !== 1'b0) begin
      errors++;
      $display("FAIL bp_next got grant=%b addr=%h want grant=0010 addr=80", req_grant, mem_req_addr);
    end
    expect_rd(1, 64'h80);
    cyc();
    set_req(1, 1'b0, 1'b0, '0);
    drain(1);
  endtask

  task automatic test_fifo_full();
    exp_t e;
    for (int k = 0; k < D; k++) begin
      cyc();
      set_req(0, 1'b1, 1'b0, 64'h2000 + 64'(k));
      #1;
      checks++;
      if (req_grant !== 4'b0001) begin
        errors++;
        $display("FAIL fill_grant k=%0d got %b want 0001", k, req_grant);
      end
      expect_rd(0, 64'h2000 + 64'(k));
    end
    cyc();
    set_req(0, 1'b1, 1'b0, 64'h3000);
    #1;
    checks++;
    if (req_grant !== '0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_read_blocked got grant=%b valid=%b want 0000/0", req_grant, mem_req_valid);
    end
    cyc();
    set_req(3, 1'b1, 1'b1, 64'h300);
    #1;
    checks++;
    if (req_grant !== 4'b1000 || mem_req_addr !== 64'h300) begin
      errors++;
      $display("FAIL full_write_pass got grant=%b addr=%h want 1000 addr=300", req_grant, mem_req_addr);
    end
    exp_writes++;
    cyc();
    set_req(3, 1'b0, 1'b0, '0);
    #1;
    checks++;
    if (req_grant !== '0) begin
      errors++;
      $display("FAIL full_still_blocked got %b want 0000", req_grant);
    end
    cyc();
    e = sb.pop_front();
    resp_grant = '1;
    mem_resp_valid = 1'b1;
    mem_resp_data = dat(e.addr);
    #1;
    checks++;
    if (req_grant !== '0 || resp_valid !== 4'b0001 || mem_resp_grant !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_cycle got grant=%b resp_valid=%b mem_resp_grant=%b want 0000/0001/1",
               req_grant, resp_valid, mem_resp_grant);
    end
    cyc();
    mem_resp_valid = 1'b0;
    resp_grant = '0;
    #1;
    checks++;
    if (req_grant !== 4'b0001 || mem_req_addr !== 64'h3000) begin
      errors++;
      $display("FAIL after_pop_grant got grant=%b addr=%h want 0001 addr=3000", req_grant, mem_req_addr);
    end
    expect_rd(0, 64'h3000);
    cyc();
    set_req(0, 1'b0, 1'b0, '0);
    drain(D);
  endtask

  task automatic test_resp_stall();
    cyc();
    set_req(3, 1'b1, 1'b0, 64'h500);
    #1;
    checks++;
    if (req_grant !== 4'b1000) begin
      errors++;
      $display("FAIL stall_issue3 got %b want 1000", req_grant);
    end
    expect_rd(3, 64'h500);
    cyc();
    set_req(3, 1'b0, 1'b0, '0);
    set_req(1, 1'b1, 1'b0, 64'h600);
    #1;
    checks++;
    if (req_grant !== 4'b0010) begin
      errors++;
      $display("FAIL stall_issue1 got %b want 0010", req_grant);
    end
    expect_rd(1, 64'h600);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) begin
        set_req(1, 1'b0, 1'b0, '0);
        resp_grant = '0;
        mem_resp_valid = 1'b1;
        mem_resp_data = dat(64'h500);
      end
      #1;
      checks++;
      if (resp_valid !== 4'b1000 || mem_resp_grant !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold k=%0d got resp_valid=%b mem_resp_grant=%b want 1000/0", k, resp_valid, mem_resp_grant);
      end
    end
    cyc();
    resp_grant = 4'b1000;
    #1;
    checks++;
    if (resp_valid !== 4'b1000 || mem_resp_grant !== 1'b1 || resp_data !== dat(64'h500)) begin
      errors++;
      $display("FAIL stall_release got resp_valid=%b mem_resp_grant=%b want 1000/1", resp_valid, mem_resp_grant);
    end
    void'(sb.pop_front());
    cyc();
    resp_grant = '0;
    mem_resp_data = dat(64'h600);
    #1;
    checks++;
    if (resp_valid !== 4'b0010 || mem_resp_grant !== 1'b0) begin
      errors++;
      $display("FAIL stall_advanced got resp_valid=%b mem_resp_grant=%b want 0010/0", resp_valid, mem_resp_grant);
    end
    drain(1);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      int want;
      cyc();
      if (k == 0) for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 64'h7000 + 64'(i));
      #1;
      want = (2 + k) % N;
      checks++;
      if (req_grant !== N'(1) << want) begin
        errors++;
        $display("FAIL mid_issue k=%0d got %b want %b", k, req_grant, N'(1) << want);
      end
      expect_rd(want, 64'h7000 + 64'(want));
    end
    cyc();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0);
    rst = 1'b1;
    #1;
    checks++;
    if (req_grant !== '0 || mem_req_valid !== 1'b0 || resp_valid !== '0 || mem_resp_grant !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_outputs got grant=%b valid=%b resp_valid=%b mem_resp_grant=%b want all 0",
               req_grant, mem_req_valid, resp_valid, mem_resp_grant);
    end
    cyc();
    rst = 1'b0;
    sb.delete();
    exp_reads = 0;
    exp_writes = 0;
    resp_grant = '1;
    #1;
    checks++;
    if (mem_resp_grant !== 1'b0 || resp_valid !== '0 || mem_req_valid !== 1'b0 || stat_reads_out !== 32'd0 || stat_writes_out !== 32'd0) begin
      errors++;
      $display("FAIL mid_after_rst got mem_resp_grant=%b resp_valid=%b stats=%0d/%0d want 0/0000/0/0",
               mem_resp_grant, resp_valid, stat_reads_out, stat_writes_out);
    end
    cyc();
    resp_grant = '0;
    set_req(2, 1'b1, 1'b0, 64'h8000);
    set_req(3, 1'b1, 1'b0, 64'h8100);
    #1;
    checks++;
    if (req_grant !== 4'b0100) begin
      errors++;
      $display("FAIL mid_rr_reset got %b want 0100", req_grant);
    end
    expect_rd(2, 64'h8000);
    cyc();
    set_req(2, 1'b0, 1'b0, '0);
    #1;
    checks++;
    if (req_grant !== 4'b1000) begin
      errors++;
      $display("FAIL mid_second got %b want 1000", req_grant);
    end
    expect_rd(3, 64'h8100);
    cyc();
    set_req(3, 1'b0, 1'b0, '0);
    drain(2);
  endtask

  task automatic test_stats();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    exp_reads = 0;
    exp_writes = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 0) for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b1, 64'h9000 + 64'(i));
      else set_req(k - 1, 1'b0, 1'b0, '0);
      #1;
      checks++;
      if (req_grant !== N'(1) << k || mem_req_iswrite !== 1'b1) begin
        errors++;
        $display("FAIL stats_write k=%0d got %b want %b", k, req_grant, N'(1) << k);
      end
      exp_writes++;
    end
    cyc();
    set_req(2, 1'b0, 1'b0, '0);
    set_req(3, 1'b1, 1'b0, 64'hA000);
    #1;
    checks++;
    if (req_grant !== 4'b1000) begin
      errors++;
      $display("FAIL stats_read3 got %b want 1000", req_grant);
    end
    expect_rd(3, 64'hA000);
    cyc();
    set_req(3, 1'b0, 1'b0, '0);
    set_req(0, 1'b1, 1'b0, 64'hA100);
    #1;
    checks++;
    if (req_grant !== 4'b0001) begin
      errors++;
      $display("FAIL stats_read0 got %b want 0001", req_grant);
    end
    expect_rd(0, 64'hA100);
    cyc();
    set_req(0, 1'b0, 1'b0, '0);
    #1;
    checks++;
    if (stat_writes_out !== (STATS ? 32'(exp_writes) : 32'd0) || stat_reads_out !== (STATS ? 32'(exp_reads) : 32'd0)) begin
      errors++;
      $display("FAIL stats_counts got writes=%0d reads=%0d want writes=%0d reads=%0d", stat_writes_out, stat_reads_out,
               STATS ? exp_writes : 0, STATS ? exp_reads : 0);
    end
    drain(2);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_fifo_full();
    test_resp_stall();
    test_reset_mid();
    test_stats();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
